// File: rtl/qdma_h2c_rx_adapter_pkg.sv
// Shared types and widths for the QDMA H2C ingress adapter.
package qdma_adapter_pkg;
  localparam int DATA_WIDTH = 512;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int MTY_WIDTH  = 6;
  localparam int QID_WIDTH  = 11;

  typedef enum logic [1:0] {IDLE, PASS, DROP, TRUNC} adapter_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  err;
    logic [QID_WIDTH-1:0]  qid;
  } beat_t;

  // mty counts empty bytes at the top of the beat, so valid bytes sit at the bottom.
  function automatic logic [KEEP_WIDTH-1:0] mty_to_keep(input logic [MTY_WIDTH-1:0] mty);
    return {KEEP_WIDTH{1'b1}} >> mty;
  endfunction
endpackage

// File: rtl/qdma_h2c_rx_adapter_if.sv
// Stream bundles: QDMA H2C ingress (mty framing) and shell-side AXI-Stream (tkeep framing).
interface qdma_h2c_if;
  import qdma_adapter_pkg::*;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [MTY_WIDTH-1:0]  tuser_mty;
  logic                  tuser_err;
  logic                  tuser_zero_byte;
  logic [QID_WIDTH-1:0]  tuser_qid;

  modport master (output tdata, tvalid, tlast, tuser_mty, tuser_err, tuser_zero_byte, tuser_qid,
                  input  tready);
  modport slave  (input  tdata, tvalid, tlast, tuser_mty, tuser_err, tuser_zero_byte, tuser_qid,
                  output tready);
endinterface

interface qdma_axis_if;
  import qdma_adapter_pkg::*;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser_err;
  logic [QID_WIDTH-1:0]  tuser_qid;

  modport master (output tdata, tkeep, tvalid, tlast, tuser_err, tuser_qid, input tready);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser_err, tuser_qid, output tready);
endinterface

// File: rtl/qdma_h2c_rx_adapter_skid_buffer.sv
// Two-entry output buffer; in_ready is a flop so downstream ready never reaches upstream combinationally.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] ent0, ent1;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       cnt, cnt_nxt;
  logic             push, pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = rd_ptr ? ent1 : ent0;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
      ent0     <= '0;
      ent1     <= '0;
    end else begin
      cnt      <= cnt_nxt;
      in_ready <= (cnt_nxt != 2'd2);
      if (push) begin
        wr_ptr <= ~wr_ptr;
        if (wr_ptr) ent1 <= in_data;
        else        ent0 <= in_data;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end
endmodule

// File: rtl/qdma_h2c_rx_adapter.sv
// QDMA H2C ingress: mty->tkeep, whole-packet drop at SOP, truncation at MAX_BEATS, saturating stats.
module qdma_h2c_rx_adapter
  import qdma_adapter_pkg::*;
#(
  parameter int MAX_BEATS = 24
) (
  input  logic        axis_aclk,
  input  logic        axis_rst,
  input  logic        cfg_enable,
  qdma_h2c_if.slave   s_axis,
  qdma_axis_if.master m_axis,
  output logic [31:0] stat_pkt_in,
  output logic [31:0] stat_pkt_drop
);
  localparam int               CNT_W    = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BEATS);
  localparam logic [KEEP_WIDTH-1:0] KEEP_ALL = '1;

  adapter_state_t       state, state_n;
  logic [CNT_W-1:0]     beat_cnt, beat_cnt_n;
  logic                 err_q, err_n;
  logic [QID_WIDTH-1:0] qid_q, qid_n;
  logic                 acc, sop_drop, skid_rdy, fwd_vld, in_inc, drop_inc, pass_err;
  logic [KEEP_WIDTH-1:0] last_keep;
  beat_t                fwd_beat, out_beat;

  // Discarding states sink beats unconditionally; they never touch the buffer.
  assign s_axis.tready = (state == DROP || state == TRUNC) ? 1'b1 : skid_rdy;
  assign acc       = s_axis.tvalid & s_axis.tready;
  assign sop_drop  = s_axis.tuser_err | s_axis.tuser_zero_byte | ~cfg_enable;
  assign last_keep = mty_to_keep(s_axis.tuser_mty);
  assign pass_err  = err_q | s_axis.tuser_err;

  always_comb begin
    state_n       = state;
    beat_cnt_n    = beat_cnt;
    err_n         = err_q;
    qid_n         = qid_q;
    fwd_vld       = 1'b0;
    in_inc        = 1'b0;
    drop_inc      = 1'b0;
    fwd_beat.data = s_axis.tdata;
    fwd_beat.keep = KEEP_ALL;
    fwd_beat.last = 1'b0;
    fwd_beat.err  = 1'b0;
    fwd_beat.qid  = qid_q;
    case (state)
      IDLE: if (acc) begin
        in_inc = 1'b1;
        if (sop_drop) begin
          drop_inc = 1'b1;
          state_n  = s_axis.tlast ? IDLE : DROP;
        end else begin
          fwd_vld      = 1'b1;
          qid_n        = s_axis.tuser_qid;
          fwd_beat.qid = s_axis.tuser_qid;
          beat_cnt_n   = CNT_W'(1);
          err_n        = 1'b0;
          if (s_axis.tlast) begin
            fwd_beat.last = 1'b1;
            fwd_beat.keep = last_keep;
          end else begin
            state_n = PASS;
          end
        end
      end
      PASS: if (acc) begin
        fwd_vld    = 1'b1;
        beat_cnt_n = beat_cnt + CNT_W'(1);
        err_n      = pass_err;
        // Real tlast wins over truncation when both land on the same beat.
        if (s_axis.tlast) begin
          fwd_beat.last = 1'b1;
          fwd_beat.keep = last_keep;
          fwd_beat.err  = pass_err;
          err_n         = 1'b0;
          state_n       = IDLE;
        end else if (beat_cnt_n == MAX_CNT) begin
          fwd_beat.last = 1'b1;
          fwd_beat.err  = 1'b1;
          err_n         = 1'b0;
          state_n       = TRUNC;
        end
      end
      default: if (acc && s_axis.tlast) state_n = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      err_q         <= 1'b0;
      qid_q         <= '0;
      stat_pkt_in   <= '0;
      stat_pkt_drop <= '0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_cnt_n;
      err_q    <= err_n;
      qid_q    <= qid_n;
      if (in_inc && stat_pkt_in != '1)     stat_pkt_in   <= stat_pkt_in + 32'd1;
      if (drop_inc && stat_pkt_drop != '1) stat_pkt_drop <= stat_pkt_drop + 32'd1;
    end
  end

  axis_skid_buffer #(.WIDTH($bits(beat_t))) u_skid (
    .clk       (axis_aclk),
    .rst       (axis_rst),
    .in_data   (fwd_beat),
    .in_valid  (fwd_vld),
    .in_ready  (skid_rdy),
    .out_data  (out_beat),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready)
  );

  assign m_axis.tdata     = out_beat.data;
  assign m_axis.tkeep     = out_beat.keep;
  assign m_axis.tlast     = out_beat.last;
  assign m_axis.tuser_err = out_beat.err;
  assign m_axis.tuser_qid = out_beat.qid;
endmodule
